ld_st_control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit datapath's memory-reference instructions.
- Generates, cycle by cycle, the control strobes for instruction fetch plus execution of ld, ldi and st, driving the same control inputs the datapath exposes.
- Sits beside the datapath: reads the IR opcode field, waits on a memory-ready handshake, and runs fetch/execute continuously until halted.

---
 rtl/ld_st_control_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_ld_st_control_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ld_st_control_sequencer.sv
// Hardwired fetch/execute sequencer for ld, ldi and st.
// Moore decode of a registered T-step plus latched opcode.
module ld_st_control_sequencer #(
  parameter logic [4:0] OP_LD  = 5'b00000,
  parameter logic [4:0] OP_LDI = 5'b00001,
  parameter logic [4:0] OP_ST  = 5'b00010
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [4:0] IR_op,
  input  logic       mem_ready,
  input  logic       stop,
  output logic       PCout,
  output logic       Zlowout,
  output logic       MDRout,
  output logic       Cout,
  output logic       BAout,
  output logic       Rout,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       MARin,
  output logic       Zin,
  output logic       PCin,
  output logic       MDRin,
  output logic       IRin,
  output logic       Yin,
  output logic       IncPC,
  output logic       ADD,
  output logic       Read,
  output logic       Write,
  output logic       run,
  output logic       illegal,
  output logic [3:0] step
);

  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  state_t     r_state;
  logic [4:0] r_op;
  logic       r_illegal;

  logic w_ld;
  logic w_ldi;
  logic w_st;
  logic w_op_ok;
  logic w_next_instr_halt;

  assign w_ld  = (r_op == OP_LD);
  assign w_ldi = (r_op == OP_LDI);
  assign w_st  = (r_op == OP_ST);

  assign w_op_ok = (IR_op == OP_LD)
                || (IR_op == OP_LDI)
                || (IR_op == OP_ST);

  assign w_next_instr_halt = stop;

  // Step sequencing, opcode latch and sticky illegal flag
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= S_RST;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_RST: r_state <= S_T0;
        S_T0:  r_state <= S_T1;
        S_T1: begin
          if (mem_ready) r_state <= S_T2;
        end
        S_T2:  r_state <= S_T3;
        S_T3: begin
          r_op <= IR_op;
          if (w_op_ok) begin
            r_state <= S_T4;
          end else begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end
        end
        S_T4:  r_state <= S_T5;
        S_T5: begin
          if (w_ldi) begin
            r_state <= w_next_instr_halt ? S_HALT : S_T0;
          end else begin
            r_state <= S_T6;
          end
        end
        S_T6: begin
          if (w_st || mem_ready) r_state <= S_T7;
        end
        S_T7: begin
          if (w_ld || mem_ready) begin
            r_state <= w_next_instr_halt ? S_HALT : S_T0;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

  // Control strobe decode from the registered step
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Cout    = 1'b0;
    BAout   = 1'b0;
    Rout    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    ADD     = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    unique case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      S_T4: begin
        Cout = 1'b1;
        ADD  = 1'b1;
        Zin  = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_ldi) begin
          Gra = 1'b1;
          Rin = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      S_T6: begin
        if (w_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (w_st) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (w_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (w_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Status and debug step encoding
  always_comb begin
    run  = 1'b0;
    step = 4'hF;
    unique case (r_state)
      S_T0: begin run = 1'b1; step = 4'd0; end
      S_T1: begin run = 1'b1; step = 4'd1; end
      S_T2: begin run = 1'b1; step = 4'd2; end
      S_T3: begin run = 1'b1; step = 4'd3; end
      S_T4: begin run = 1'b1; step = 4'd4; end
      S_T5: begin run = 1'b1; step = 4'd5; end
      S_T6: begin run = 1'b1; step = 4'd6; end
      S_T7: begin run = 1'b1; step = 4'd7; end
      default: ;
    endcase
  end

  assign illegal = r_illegal;

endmodule

// File: tb/tb_ld_st_control_sequencer.sv
// Scoreboard bench: planned per-instruction timelines
// drive the sequencer; a monitor checks every cycle.
module tb_ld_st_control_sequencer;

  localparam logic [4:0] LD  = 5'b00000;
  localparam logic [4:0] LDI = 5'b00001;
  localparam logic [4:0] ST  = 5'b00010;

  localparam logic [19:0] PCO  = 20'h80000;
  localparam logic [19:0] ZLO  = 20'h40000;
  localparam logic [19:0] MDRO = 20'h20000;
  localparam logic [19:0] CO   = 20'h10000;
  localparam logic [19:0] BAO  = 20'h08000;
  localparam logic [19:0] RO   = 20'h04000;
  localparam logic [19:0] GRA  = 20'h02000;
  localparam logic [19:0] GRB  = 20'h01000;
  localparam logic [19:0] RIN  = 20'h00400;
  localparam logic [19:0] MARI = 20'h00200;
  localparam logic [19:0] ZIN  = 20'h00100;
  localparam logic [19:0] PCI  = 20'h00080;
  localparam logic [19:0] MDRI = 20'h00040;
  localparam logic [19:0] IRI  = 20'h00020;
  localparam logic [19:0] YIN  = 20'h00010;
  localparam logic [19:0] INC  = 20'h00008;
  localparam logic [19:0] ADDM = 20'h00004;
  localparam logic [19:0] RD   = 20'h00002;
  localparam logic [19:0] WR   = 20'h00001;

  typedef struct packed {
    logic        clr;
    logic [4:0]  op;
    logic        mr;
    logic        stp;
    logic [25:0] exp;
  } ent_t;

  logic clk = 1'b0;
  logic clear;
  logic [4:0] IR_op;
  logic mem_ready;
  logic stop;
  logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic Gra, Grb, Grc;
  logic Rin, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic IncPC, ADD, Read, Write, run, illegal;
  logic [3:0] step;

  int checks = 0;
  int errors = 0;
  bit m_ill = 1'b0;
  ent_t plan[$];
  logic [25:0] sb[$];
  logic [25:0] act;

  ld_st_control_sequencer dut (
    .clk(clk), .clear(clear), .IR_op(IR_op),
    .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .ADD(ADD), .Read(Read), .Write(Write),
    .run(run), .illegal(illegal), .step(step)
  );

  always #5 clk = ~clk;

  assign act = {PCout, Zlowout, MDRout, Cout, BAout, Rout,
                Gra, Grb, Grc, Rin, MARin, Zin, PCin,
                MDRin, IRin, Yin, IncPC, ADD, Read, Write,
                run, illegal, step};

  // t = 0..7 running step, -1 reset, -2 halt
  function automatic ent_t mk(logic [19:0] s, int t);
    ent_t e;
    logic [3:0] st;
    st = (t >= 0) ? 4'(t) : 4'hF;
    e.clr = 1'b0;
    e.op  = 5'($urandom);
    e.mr  = 1'($urandom);
    e.stp = 1'($urandom);
    e.exp = {s, (t >= 0), m_ill, st};
    return e;
  endfunction

  task automatic plan_instr(input logic [4:0] op,
                            input int w1, input int w2,
                            input bit stp, input int abort,
                            input int nhalt);
    ent_t cur[$];
    ent_t e;
    bit legal;
    legal = (op == LD) || (op == LDI) || (op == ST);
    cur.push_back(mk(PCO | MARI | INC | ZIN, 0));
    for (int i = 0; i <= w1; i++) begin
      e = mk(ZLO | PCI | RD | MDRI, 1);
      e.mr = (i == w1);
      cur.push_back(e);
    end
    cur.push_back(mk(MDRO | IRI, 2));
    e = mk(GRB | BAO | YIN, 3);
    e.op = op;
    cur.push_back(e);
    if (legal) begin
      cur.push_back(mk(CO | ADDM | ZIN, 4));
      if (op == LDI) begin
        cur.push_back(mk(ZLO | GRA | RIN, 5));
      end else if (op == LD) begin
        cur.push_back(mk(ZLO | MARI, 5));
        for (int i = 0; i <= w2; i++) begin
          e = mk(RD | MDRI, 6);
          e.mr = (i == w2);
          cur.push_back(e);
        end
        cur.push_back(mk(MDRO | GRA | RIN, 7));
      end else begin
        cur.push_back(mk(ZLO | MARI, 5));
        cur.push_back(mk(GRA | RO | MDRI, 6));
        for (int i = 0; i <= w2; i++) begin
          e = mk(WR, 7);
          e.mr = (i == w2);
          cur.push_back(e);
        end
      end
      e = cur.pop_back();
      e.stp = stp;
      cur.push_back(e);
    end
    if (abort >= 0 && abort < cur.size()) begin
      while (cur.size() > abort + 1) void'(cur.pop_back());
      e = cur.pop_back();
      e.clr = 1'b1;
      cur.push_back(e);
      m_ill = 1'b0;
      cur.push_back(mk(20'h0, -1));
    end else if (!legal || stp) begin
      if (!legal) m_ill = 1'b1;
      for (int i = 0; i < nhalt; i++) begin
        e = mk(20'h0, -2);
        e.clr = (i == nhalt - 1);
        cur.push_back(e);
      end
      m_ill = 1'b0;
      cur.push_back(mk(20'h0, -1));
    end
    foreach (cur[i]) plan.push_back(cur[i]);
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [25:0] ex;
      ex = sb.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL outputs step=%h got=%h want=%h",
                 ex[3:0], act, ex);
      end
      checks++;
      if ($countones({PCout, Zlowout, MDRout,
                      Cout, BAout, Rout}) > 1) begin
        errors++;
        $display("FAIL bus_drivers got=%b want<=1 driver",
                 act[25:20]);
      end
      checks++;
      if (Read && Write) begin
        errors++;
        $display("FAIL rd_wr got=11 want not both");
      end
      checks++;
      if (Write && (step !== 4'd7 || ex[0] !== 1'b1)) begin
        errors++;
        $display("FAIL write_place got step=%h want st T7", step);
      end
    end
  end

  initial begin
    logic [4:0] op;
    ent_t e;
    int k;
    clear = 1'b1;
    IR_op = 5'h0;
    mem_ready = 1'b0;
    stop = 1'b0;
    plan.push_back(mk(20'h0, -1));
    plan_instr(LD, 0, 0, 0, -1, 0);
    plan_instr(LD, 0, 3, 0, -1, 0);
    plan_instr(LDI, 0, 0, 0, -1, 0);
    plan_instr(ST, 1, 2, 0, -1, 0);
    plan_instr(5'h1F, 0, 0, 0, -1, 3);
    plan_instr(LD, 0, 0, 1, -1, 2);
    plan_instr(LD, 0, 0, 0, 5, 0);
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      op = (k < 3) ? LD : (k < 6) ? LDI : (k < 9) ? ST
         : 5'($urandom_range(3, 31));
      plan_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0)
                   ? $urandom_range(0, 9) : -1,
                 $urandom_range(1, 3));
    end
    @(posedge clk);
    #1;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      clear = e.clr;
      IR_op = e.op;
      mem_ready = e.mr;
      stop = e.stp;
      sb.push_back(e.exp);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want 0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
